// File: rtl/keypad_entry.sv
`default_nettype none
// ==========================================================================
// keypad_entry : signed decimal operand entry buffer with point, sign, edit
//                keys and a valid/ready hand-off to the downstream converter.
// Rev 1.0
// ==========================================================================
module keypad_entry #(
   parameter int         DIGITS    = 5,
   parameter logic [3:0] KEY_DP    = 4'hA,
   parameter logic [3:0] KEY_BS    = 4'hB,
   parameter logic [3:0] KEY_CLR   = 4'hC,
   parameter logic [3:0] KEY_SIGN  = 4'hD,
   parameter logic [3:0] KEY_ENTER = 4'hE,
   localparam int        CW        = $clog2(DIGITS+1)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [3:0]          key_val,
   input  logic                key_valid,
   output logic [DIGITS*4-1:0] digits,
   output logic [CW-1:0]       count,
   output logic                dp_set,
   output logic [CW-1:0]       dp_pos,
   output logic                neg,
   output logic                num_valid,
   input  logic                num_ready,
   output logic                err
);

   localparam logic [1:0]    c_EMPTY = 2'd0;
   localparam logic [1:0]    c_ENTRY = 2'd1;
   localparam logic [1:0]    c_DONE  = 2'd2;
   localparam logic [CW-1:0] c_MAX   = CW'(DIGITS);
   localparam logic [CW-1:0] c_ONE   = CW'(1);

   logic [1:0]          r_state,  w_state;
   logic [DIGITS*4-1:0] r_digits, w_digits;
   logic [CW-1:0]       r_count,  w_count;
   logic                r_dp_set, w_dp_set;
   logic [CW-1:0]       r_dp_pos, w_dp_pos;
   logic                r_neg,    w_neg;
   logic                r_num_valid;
   logic                r_err,    w_err;
   logic                w_is_digit;
   logic                w_is_clr;

   assign w_is_digit = (key_val <= 4'd9);
   assign w_is_clr   = key_valid && (key_val == KEY_CLR);

   always_comb begin
      w_state  = r_state;
      w_digits = r_digits;
      w_count  = r_count;
      w_dp_set = r_dp_set;
      w_dp_pos = r_dp_pos;
      w_neg    = r_neg;
      w_err    = 1'b0;
      if (r_state == c_DONE) begin
         // Operand is frozen; only the handshake or CLR releases it.
         if (num_ready || w_is_clr) begin
            w_state  = c_EMPTY;
            w_digits = '0;
            w_count  = '0;
            w_dp_set = 1'b0;
            w_dp_pos = '0;
            w_neg    = 1'b0;
         end
         if (key_valid && !w_is_clr)
            w_err = 1'b1;
      end else if (key_valid) begin
         if (w_is_digit) begin
            if (r_count < c_MAX) begin
               w_digits = {r_digits[DIGITS*4-5:0], key_val};
               w_count  = r_count + c_ONE;
               if (r_dp_set)
                  w_dp_pos = r_dp_pos + c_ONE;
               w_state  = c_ENTRY;
            end else begin
               w_err = 1'b1;
            end
         end else if (key_val == KEY_DP) begin
            if (!r_dp_set) begin
               w_dp_set = 1'b1;
               w_dp_pos = '0;
               w_state  = c_ENTRY;
            end else begin
               w_err = 1'b1;
            end
         end else if (key_val == KEY_BS) begin
            // A bare trailing point is removed before any digit.
            if (r_dp_set && (r_dp_pos == '0)) begin
               w_dp_set = 1'b0;
            end else if (r_count != '0) begin
               w_digits = {4'h0, r_digits[DIGITS*4-1:4]};
               w_count  = r_count - c_ONE;
               if (r_dp_set)
                  w_dp_pos = r_dp_pos - c_ONE;
            end else begin
               w_err = 1'b1;
            end
            if ((w_count == '0) && !w_dp_set)
               w_state = c_EMPTY;
         end else if (key_val == KEY_SIGN) begin
            w_neg = ~r_neg;
         end else if (key_val == KEY_ENTER) begin
            if ((r_state == c_ENTRY) && (r_count != '0))
               w_state = c_DONE;
            else
               w_err = 1'b1;
         end else if (key_val == KEY_CLR) begin
            w_state  = c_EMPTY;
            w_digits = '0;
            w_count  = '0;
            w_dp_set = 1'b0;
            w_dp_pos = '0;
            w_neg    = 1'b0;
         end else begin
            w_err = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= c_EMPTY;
         r_digits    <= '0;
         r_count     <= '0;
         r_dp_set    <= 1'b0;
         r_dp_pos    <= '0;
         r_neg       <= 1'b0;
         r_num_valid <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_state     <= w_state;
         r_digits    <= w_digits;
         r_count     <= w_count;
         r_dp_set    <= w_dp_set;
         r_dp_pos    <= w_dp_pos;
         r_neg       <= w_neg;
         r_num_valid <= (w_state == c_DONE);
         r_err       <= w_err;
      end
   end

   assign digits    = r_digits;
   assign count     = r_count;
   assign dp_set    = r_dp_set;
   assign dp_pos    = r_dp_pos;
   assign neg       = r_neg;
   assign num_valid = r_num_valid;
   assign err       = r_err;

endmodule
`default_nettype wire
